// File: rtl/cory_tpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cory_tpram_fifo_ctrl
// Description : Single-clock valid/ready FIFO controller driving an external
//               two-port RAM (active-low enables, one-cycle registered read).
//               A 2-entry output buffer hides the RAM read latency so the FIFO
//               moves one word per cycle in each direction.
//               Ports:
//                 clk, reset_n          clock, async active-low reset
//                 clr                   synchronous flush
//                 i_vld/i_rdy/i_data    producer stream
//                 o_vld/o_rdy/o_data    consumer stream
//                 count                 words held (RAM + landing + buffer)
//                 mem_wen/waddr/wdata   RAM write port
//                 mem_ren/raddr/rdata   RAM read port
// Revision    : 1.0 - initial release
// ============================================================================
module cory_tpram_fifo_ctrl #(
    parameter int A = 4,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         i_vld,
    output logic         i_rdy,
    input  logic [D-1:0] i_data,
    output logic         o_vld,
    input  logic         o_rdy,
    output logic [D-1:0] o_data,
    output logic [A+1:0] count,
    output logic         mem_wen,
    output logic [A-1:0] mem_waddr,
    output logic [D-1:0] mem_wdata,
    output logic         mem_ren,
    output logic [A-1:0] mem_raddr,
    input  logic [D-1:0] mem_rdata
);

    localparam int         DEPTH   = 1 << A;
    localparam logic [A:0] C_DEPTH = (A+1)'(DEPTH);

    logic         en_q,      en_d;
    logic [A-1:0] wptr_q,    wptr_d;
    logic [A-1:0] rptr_q,    rptr_d;
    logic [A:0]   ram_cnt_q, ram_cnt_d;
    logic         land_q,    land_d;
    logic [D-1:0] ob0_q,     ob0_d;     // oldest buffered word
    logic [D-1:0] ob1_q,     ob1_d;
    logic [1:0]   ob_cnt_q,  ob_cnt_d;

    logic         push;
    logic         pop;
    logic         issue;
    logic [2:0]   ob_need;
    logic [1:0]   ob_after_pop;

    always_comb begin
        en_d    = 1'b1;

        i_rdy   = en_q & ~clr & (ram_cnt_q < C_DEPTH);
        push    = i_vld & i_rdy;
        o_vld   = (ob_cnt_q != 2'd0) & ~clr;
        pop     = o_vld & o_rdy;

        // A read may only issue if its word will still have a buffer slot
        // when it lands, counting the word already in flight.
        ob_need = {1'b0, ob_cnt_q} + {2'b00, land_q} + 3'd1;
        issue   = en_q & ~clr & (ram_cnt_q != '0) & (ob_need <= (3'd2 + {2'b00, pop}));

        mem_wen   = ~push;
        mem_waddr = wptr_q;
        mem_wdata = i_data;
        mem_ren   = ~issue;
        mem_raddr = rptr_q;
        o_data    = ob0_q;

        count = (A+2)'(ram_cnt_q) + (A+2)'(land_q) + (A+2)'(ob_cnt_q);

        wptr_d    = wptr_q + A'(push);
        rptr_d    = rptr_q + A'(issue);
        ram_cnt_d = ram_cnt_q + (A+1)'(push) - (A+1)'(issue);
        land_d    = issue;

        // Remove the popped word first, then append the landing word
        // behind whatever remains.
        ob_after_pop = ob_cnt_q - {1'b0, pop};
        ob0_d        = ob0_q;
        ob1_d        = ob1_q;
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (land_q) begin
            if (ob_after_pop == 2'd0) begin
                ob0_d = mem_rdata;
            end else begin
                ob1_d = mem_rdata;
            end
        end
        ob_cnt_d = ob_after_pop + {1'b0, land_q};

        // Flush drops everything, including a read landing this cycle.
        if (clr) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            land_d    = 1'b0;
            ob_cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            land_q    <= 1'b0;
            ob0_q     <= '0;
            ob1_q     <= '0;
            ob_cnt_q  <= 2'd0;
        end else begin
            en_q      <= en_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            land_q    <= land_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
            ob_cnt_q  <= ob_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cory_tpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cory_tpram_fifo_ctrl
// Description : Self-checking bench for cory_tpram_fifo_ctrl with a behavioural
//               two-port RAM and a queue scoreboard of accepted words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cory_tpram_fifo_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       i_vld;
    logic       i_rdy;
    logic [7:0] i_data;
    logic       o_vld;
    logic       o_rdy;
    logic [7:0] o_data;
    logic [5:0] count;
    logic       mem_wen;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       mem_ren;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];
    logic [7:0] ram [16];

    cory_tpram_fifo_ctrl #(.A(4), .D(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .i_vld     (i_vld),
        .i_rdy     (i_rdy),
        .i_data    (i_data),
        .o_vld     (o_vld),
        .o_rdy     (o_rdy),
        .o_data    (o_data),
        .count     (count),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_wen) ram[mem_waddr] <= mem_wdata;
        if (!mem_ren) mem_rdata <= ram[mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample: occupancy and collision checks, then scoreboard.
    task automatic sample();
        @(negedge clk);
        if (!reset_n) sb.delete();
        check("count_vs_sb", 32'(count), sb.size());
        check("count_max", 32'(count <= 6'd18), 1);
        check("collision", 32'(!mem_wen && !mem_ren && (mem_waddr == mem_raddr)), 0);
        if (reset_n && !clr) begin
            if (o_vld && o_rdy) begin
                check("underflow", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("order", 32'(o_data), 32'(sb.pop_front()));
            end
            if (i_vld && i_rdy) sb.push_back(i_data);
        end
        if (clr) sb.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_first(input logic [7:0] v, input string tag);
        logic got;
        logic done_push;
        got   = 1'b0;
        i_vld = 1'b1;
        i_data = v;
        o_rdy = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            sample();
            done_push = i_vld && i_rdy;
            if (o_vld) begin
                check(tag, 32'(o_data), 32'(v));
                got = 1'b1;
            end
            tick();
            if (done_push) i_vld = 1'b0;
        end
        check({tag, "_seen"}, 32'(got), 1);
        i_vld = 1'b0;
    endtask

    initial begin
        int acc;
        int sent;
        int popped;
        int last;
        logic stall;

        reset_n = 1'b0;
        clr     = 1'b0;
        i_vld   = 1'b1;
        i_data  = 8'h11;
        o_rdy   = 1'b0;

        // Reset held with i_vld high
        repeat (3) begin
            sample();
            check("rst_irdy", 32'(i_rdy), 0);
            check("rst_ovld", 32'(o_vld), 0);
            check("rst_wen", 32'(mem_wen), 1);
            check("rst_ren", 32'(mem_ren), 1);
            tick();
        end
        reset_n = 1'b1;
        i_vld   = 1'b0;
        sample();
        check("rel_irdy1", 32'(i_rdy), 0);
        tick();
        sample();
        check("rel_irdy2", 32'(i_rdy), 1);
        tick();

        // Single word latency
        i_vld = 1'b1; i_data = 8'hA5; o_rdy = 1'b1;
        sample();
        check("sw_wen", 32'(mem_wen), 0);
        check("sw_waddr", 32'(mem_waddr), 0);
        tick();
        i_vld = 1'b0;
        sample();
        check("sw_ren", 32'(mem_ren), 0);
        check("sw_raddr", 32'(mem_raddr), 0);
        tick();
        sample();
        check("sw_ovld_n2", 32'(o_vld), 0);
        tick();
        sample();
        check("sw_ovld_n3", 32'(o_vld), 1);
        check("sw_data", 32'(o_data), 32'h A5);
        tick();
        sample();
        check("sw_count", 32'(count), 0);
        tick();

        // Fill to capacity with the consumer stalled
        o_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 60 && acc < 18; c++) begin
            i_vld = 1'b1;
            i_data = acc[7:0];
            sample();
            if (i_rdy) acc++;
            tick();
        end
        check("fill_acc", acc, 18);
        i_data = 8'hEE;
        repeat (4) begin
            sample();
            check("full_irdy", 32'(i_rdy), 0);
            check("full_count", 32'(count), 18);
            tick();
        end
        i_vld = 1'b0;
        o_rdy = 1'b1;
        for (int k = 0; k < 18; k++) begin
            sample();
            check("drain_ovld", 32'(o_vld), 1);
            if (k == 0) check("drain_irdy0", 32'(i_rdy), 0);
            if (k == 1) check("drain_irdy1", 32'(i_rdy), 1);
            tick();
        end
        sample();
        check("drain_count", 32'(count), 0);
        tick();

        // Continuous streaming across pointer wrap
        sent = 0; popped = 0; last = -1;
        for (int c = 0; c < 300 && popped < 100; c++) begin
            i_vld  = (sent < 100);
            i_data = sent[7:0] + 8'h40;
            o_rdy  = 1'b1;
            sample();
            if (i_vld && i_rdy) sent++;
            if (o_vld && o_rdy) begin
                popped++;
                last = c;
            end
            tick();
        end
        check("stream_sent", sent, 100);
        check("stream_popped", popped, 100);
        check("stream_last", last, 102);
        i_vld = 1'b0;

        // Random backpressure
        stall = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!stall) begin
                i_vld  = 1'($urandom_range(0, 1));
                i_data = 8'($urandom);
            end
            o_rdy = 1'($urandom_range(0, 1));
            sample();
            stall = i_vld && !i_rdy;
            tick();
        end
        i_vld = 1'b0;
        o_rdy = 1'b1;
        repeat (40) begin
            sample();
            tick();
        end
        sample();
        check("rand_drain_count", 32'(count), 0);
        check("rand_drain_sb", sb.size(), 0);
        tick();

        // Flush with a read landing
        o_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 40 && acc < 11; c++) begin
            i_vld = 1'b1;
            i_data = 8'h80 + acc[7:0];
            sample();
            if (i_rdy) acc++;
            tick();
        end
        i_vld = 1'b0;
        repeat (4) begin
            sample();
            tick();
        end
        o_rdy = 1'b1;
        sample();
        check("fl_pop_vld", 32'(o_vld), 1);
        tick();
        o_rdy = 1'b0;
        clr = 1'b1;
        i_vld = 1'b1;
        i_data = 8'h55;
        sample();
        check("fl_count_before", 32'(count), 10);
        check("fl_irdy_clr", 32'(i_rdy), 0);
        check("fl_ovld_clr", 32'(o_vld), 0);
        tick();
        clr = 1'b0;
        i_vld = 1'b0;
        sample();
        check("fl_count_after", 32'(count), 0);
        check("fl_ovld_after", 32'(o_vld), 0);
        tick();
        push_first(8'h3C, "fl_first");
        repeat (3) begin
            sample();
            tick();
        end

        // Reset pulsed mid-stream
        for (int c = 0; c < 20; c++) begin
            i_vld  = 1'b1;
            i_data = 8'hC0 + c[7:0];
            o_rdy  = (c % 3 != 0);
            sample();
            tick();
        end
        reset_n = 1'b0;
        i_vld = 1'b0;
        o_rdy = 1'b0;
        sample();
        check("mr_count", 32'(count), 0);
        check("mr_ovld", 32'(o_vld), 0);
        check("mr_wen", 32'(mem_wen), 1);
        check("mr_ren", 32'(mem_ren), 1);
        tick();
        reset_n = 1'b1;
        sample();
        check("mr_irdy1", 32'(i_rdy), 0);
        check("mr_wen_en0", 32'(mem_wen), 1);
        tick();
        sample();
        check("mr_irdy2", 32'(i_rdy), 1);
        tick();
        push_first(8'h3C, "mr_first");
        repeat (3) begin
            sample();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
